// File: rtl/perf_counter_bank.sv
// Performance-counter bank: edge-detects IFU/ICache/LSU status levels into event and
// cycle counters, read through a valid/ready port with a tear-free high-word snapshot.
module perf_counter_bank #(
    parameter int unsigned CNT_W     = 64,
    parameter logic [31:0] MMIO_BASE = 32'ha000_0000,
    parameter logic [31:0] MMIO_END  = 32'hc000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear,
    input  logic        ifu_valid,
    input  logic        icache_valid,
    input  logic        icache_start,
    input  logic        icache_isHit,
    input  logic        lsu_ren,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_isWaiting,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_idx,
    input  logic        req_hi,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data
);

    localparam int NUM_EV = 8;

    // prev bit order: {lsu_isWaiting, icache_valid, icache_start, ifu_valid}
    logic [3:0]       prev_q, prev_d;
    logic [3:0]       rise_s;
    logic             mmio_s;
    logic [NUM_EV-1:0] inc_s;

    // counter 0 is kept apart from the event counters 1..8 (ev_q[0..7])
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ev_q [NUM_EV];
    logic [CNT_W-1:0] ev_d [NUM_EV];

    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [31:0]      snap_q, snap_d;
    logic [CNT_W-1:0] sel_s;
    logic [31:0]      sel_hi_s;
    logic             req_ready_s;
    logic             accept_s;

    // Edge detection and per-event increment qualifiers
    always_comb begin
        prev_d   = {lsu_isWaiting, icache_valid, icache_start, ifu_valid};
        rise_s   = prev_d & ~prev_q;
        mmio_s   = (lsu_addr >= MMIO_BASE) && (lsu_addr < MMIO_END);
        inc_s[0] = rise_s[0];
        inc_s[1] = rise_s[1];
        inc_s[2] = rise_s[2] & icache_isHit;
        inc_s[3] = rise_s[2] & ~icache_isHit;
        inc_s[4] = rise_s[3] & lsu_ren;
        inc_s[5] = rise_s[3] & lsu_wen;
        inc_s[6] = lsu_isWaiting;
        inc_s[7] = rise_s[3] & (lsu_ren | lsu_wen) & mmio_s;
    end

    // Counter next-state: clear wins over increment, disable freezes
    always_comb begin
        cyc_d = cyc_q;
        for (int i = 0; i < NUM_EV; i++) begin
            ev_d[i] = ev_q[i];
        end
        if (clear) begin
            cyc_d = '0;
            for (int i = 0; i < NUM_EV; i++) begin
                ev_d[i] = '0;
            end
        end else if (enable) begin
            cyc_d = cyc_q + {{(CNT_W-1){1'b0}}, 1'b1};
            for (int i = 0; i < NUM_EV; i++) begin
                ev_d[i] = ev_q[i] + {{(CNT_W-1){1'b0}}, inc_s[i]};
            end
        end else begin
            cyc_d = cyc_q;
        end
    end

    // Read-port counter select; out-of-range indices read as zero
    always_comb begin
        sel_s = '0;
        case (req_idx)
            4'd0:    sel_s = cyc_q;
            4'd1:    sel_s = ev_q[0];
            4'd2:    sel_s = ev_q[1];
            4'd3:    sel_s = ev_q[2];
            4'd4:    sel_s = ev_q[3];
            4'd5:    sel_s = ev_q[4];
            4'd6:    sel_s = ev_q[5];
            4'd7:    sel_s = ev_q[6];
            4'd8:    sel_s = ev_q[7];
            default: sel_s = '0;
        endcase
        sel_hi_s = 32'(sel_s >> 32);
    end

    // Response hold/handshake; a low read refreshes the high-word snapshot
    always_comb begin
        req_ready_s = ~rsp_valid_q | rsp_ready;
        accept_s    = req_valid & req_ready_s;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        snap_d      = snap_q;
        if (accept_s) begin
            rsp_valid_d = 1'b1;
            if (req_hi) begin
                rsp_data_d = snap_q;
            end else begin
                rsp_data_d = sel_s[31:0];
                snap_d     = sel_hi_s;
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_q      <= 4'b0000;
            cyc_q       <= '0;
            for (int i = 0; i < NUM_EV; i++) begin
                ev_q[i] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0000_0000;
            snap_q      <= 32'h0000_0000;
        end else begin
            prev_q      <= prev_d;
            cyc_q       <= cyc_d;
            for (int i = 0; i < NUM_EV; i++) begin
                ev_q[i] <= ev_d[i];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            snap_q      <= snap_d;
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed self-checking bench for perf_counter_bank.
module tb_perf_counter_bank;

    logic        clock = 1'b0;
    logic        reset, enable, clear;
    logic        ifu_valid, icache_valid, icache_start, icache_isHit;
    logic        lsu_ren, lsu_wen, lsu_isWaiting;
    logic [31:0] lsu_addr;
    logic        req_valid, req_ready, req_hi, rsp_valid, rsp_ready;
    logic [3:0]  req_idx;
    logic [31:0] rsp_data;

    int checks = 0;
    int errors = 0;

    perf_counter_bank dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .ifu_valid(ifu_valid), .icache_valid(icache_valid),
        .icache_start(icache_start), .icache_isHit(icache_isHit),
        .lsu_ren(lsu_ren), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
        .lsu_isWaiting(lsu_isWaiting),
        .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
        .req_hi(req_hi), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One read transaction; returns data and rsp_valid seen right after the accept edge
    task automatic do_read(input logic [3:0] idx, input logic hi,
                           output logic [31:0] data, output logic valid);
        int waited = 0;
        req_idx   = idx;
        req_hi    = hi;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && waited < 20) begin
            tick(1);
            waited++;
        end
        checks++;
        if (waited >= 20) begin
            errors++;
            $display("FAIL read_timeout: req_ready=%b, expected 1", req_ready);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        data  = rsp_data;
        valid = rsp_valid;
    endtask

    task automatic test_reset();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: rsp_valid=%b rsp_data=%h req_ready=%b, expected 0 0 1",
                     rsp_valid, rsp_data, req_ready);
        end
    endtask

    task automatic test_cycles();
        logic [31:0] d;
        logic v;
        enable = 1'b1;
        tick(10);
        do_read(4'd0, 1'b0, d, v);
        checks++;
        if (d !== 32'd10 || v !== 1'b1) begin
            errors++;
            $display("FAIL cycles_lo: got %0d valid=%b, expected 10 valid=1", d, v);
        end
        do_read(4'd0, 1'b1, d, v);
        checks++;
        if (d !== 32'd0 || v !== 1'b1) begin
            errors++;
            $display("FAIL cycles_hi: got %0d valid=%b, expected 0 valid=1", d, v);
        end
    endtask

    task automatic test_ifu();
        logic [31:0] d;
        logic v;
        repeat (3) begin
            ifu_valid = 1'b1; tick(2);
            ifu_valid = 1'b0; tick(1);
        end
        do_read(4'd1, 1'b0, d, v);
        checks++;
        if (d !== 32'd3 || v !== 1'b1) begin
            errors++;
            $display("FAIL ifu_rise: got %0d valid=%b, expected 3", d, v);
        end
    endtask

    task automatic test_icache();
        logic [31:0] d;
        logic v;
        int idxs [6] = '{3, 4, 3, 4, 2, 0};
        int exps [6] = '{1, 0, 1, 1, 1, 0};
        icache_isHit = 1'b1; icache_valid = 1'b1; tick(5);
        icache_valid = 1'b0; tick(1);
        for (int i = 0; i < 2; i++) begin
            do_read(4'(idxs[i]), 1'b0, d, v);
            checks++;
            if (d !== 32'(exps[i]) || v !== 1'b1) begin
                errors++;
                $display("FAIL icache_hit idx%0d: got %0d, expected %0d", idxs[i], d, exps[i]);
            end
        end
        icache_isHit = 1'b0; icache_valid = 1'b1; tick(2);
        icache_valid = 1'b0; tick(1);
        icache_start = 1'b1; tick(2);
        icache_start = 1'b0; tick(1);
        for (int i = 2; i < 5; i++) begin
            do_read(4'(idxs[i]), 1'b0, d, v);
            checks++;
            if (d !== 32'(exps[i]) || v !== 1'b1) begin
                errors++;
                $display("FAIL icache_miss idx%0d: got %0d, expected %0d", idxs[i], d, exps[i]);
            end
        end
    endtask

    task automatic lsu_pulse(input logic ren, input logic wen, input logic [31:0] addr, input int n);
        lsu_ren = ren; lsu_wen = wen; lsu_addr = addr; lsu_isWaiting = 1'b1;
        tick(n);
        lsu_isWaiting = 1'b0; lsu_ren = 1'b0; lsu_wen = 1'b0;
        tick(1);
    endtask

    task automatic test_lsu();
        logic [31:0] d;
        logic v;
        int idxs [4] = '{5, 6, 7, 8};
        int exp1 [4] = '{1, 0, 4, 1};
        int exp2 [4] = '{1, 1, 8, 1};
        int exp3 [4] = '{3, 3, 12, 2};
        lsu_pulse(1'b1, 1'b0, 32'ha000_0010, 4);
        for (int i = 0; i < 4; i++) begin
            do_read(4'(idxs[i]), 1'b0, d, v);
            checks++;
            if (d !== 32'(exp1[i]) || v !== 1'b1) begin
                errors++;
                $display("FAIL lsu_load idx%0d: got %0d, expected %0d", idxs[i], d, exp1[i]);
            end
        end
        lsu_pulse(1'b0, 1'b1, 32'h8000_0000, 4);
        for (int i = 0; i < 4; i++) begin
            do_read(4'(idxs[i]), 1'b0, d, v);
            checks++;
            if (d !== 32'(exp2[i]) || v !== 1'b1) begin
                errors++;
                $display("FAIL lsu_store idx%0d: got %0d, expected %0d", idxs[i], d, exp2[i]);
            end
        end
        lsu_pulse(1'b1, 1'b0, 32'hc000_0000, 1);
        lsu_pulse(1'b0, 1'b1, 32'h9fff_ffff, 1);
        lsu_pulse(1'b1, 1'b1, 32'ha000_0000, 1);
        lsu_pulse(1'b0, 1'b0, 32'hb000_0000, 1);
        for (int i = 0; i < 4; i++) begin
            do_read(4'(idxs[i]), 1'b0, d, v);
            checks++;
            if (d !== 32'(exp3[i]) || v !== 1'b1) begin
                errors++;
                $display("FAIL lsu_bounds idx%0d: got %0d, expected %0d", idxs[i], d, exp3[i]);
            end
        end
    endtask

    task automatic test_clear_disable();
        logic [31:0] d;
        logic v;
        int idxs [5] = '{0, 1, 7, 5, 8};
        clear = 1'b1; ifu_valid = 1'b1;
        tick(1);
        clear = 1'b0; ifu_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_read(4'(idxs[i]), 1'b0, d, v);
            checks++;
            if (d !== 32'd0 || v !== 1'b1) begin
                errors++;
                $display("FAIL clear idx%0d: got %0d, expected 0", idxs[i], d);
            end
        end
        enable = 1'b0; ifu_valid = 1'b1;
        tick(5);
        enable = 1'b1;
        tick(1);
        ifu_valid = 1'b0;
        tick(1);
        do_read(4'd0, 1'b0, d, v);
        checks++;
        if (d !== 32'd7) begin
            errors++;
            $display("FAIL disable_cycles: got %0d, expected 7", d);
        end
        do_read(4'd1, 1'b0, d, v);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL disable_rise_dropped: got %0d, expected 0", d);
        end
        ifu_valid = 1'b1; tick(1);
        ifu_valid = 1'b0; tick(1);
        do_read(4'd1, 1'b0, d, v);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL rise_after_clear: got %0d, expected 1", d);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic v;
        logic       his  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exps [7] = '{32'h0, 32'h3, 32'h1, 32'hffff_ffff, 32'hffff_ffff, 32'h0, 32'h0};
        force dut.cyc_q = 64'h0000_0000_ffff_ffff;
        do_read(4'd0, 1'b0, d, v);
        release dut.cyc_q;
        checks++;
        if (d !== 32'hffff_ffff) begin
            errors++;
            $display("FAIL wrap32_lo: got %h, expected ffffffff", d);
        end
        tick(3);
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                force dut.cyc_q = 64'hffff_ffff_ffff_ffff;
            end
            do_read(4'd0, his[i], d, v);
            if (i == 3) begin
                release dut.cyc_q;
            end
            checks++;
            if (d !== exps[i] || v !== 1'b1) begin
                errors++;
                $display("FAIL wrap_step%0d hi=%b: got %h, expected %h", i, his[i], d, exps[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int idxs [4] = '{12, 1, 12, 1};
        int exps [4] = '{0, 1, 0, 1};
        rsp_ready = 1'b1;
        tick(1);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_drop: rsp_valid=%b, expected 0", rsp_valid);
        end
        rsp_ready = 1'b0; req_valid = 1'b1; req_hi = 1'b0; req_idx = 4'd1;
        tick(1);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_accept: valid=%b data=%0d ready=%b, expected 1 1 0",
                     rsp_valid, rsp_data, req_ready);
        end
        req_idx = 4'd12;
        tick(3);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: valid=%b data=%0d ready=%b, expected 1 1 0",
                     rsp_valid, rsp_data, req_ready);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_idx = 4'(idxs[i]);
            tick(1);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'(exps[i])) begin
                errors++;
                $display("FAIL b2b_%0d idx%0d: valid=%b data=%0d, expected 1 %0d",
                         i, idxs[i], rsp_valid, rsp_data, exps[i]);
            end
        end
        req_valid = 1'b0;
        tick(1);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: rsp_valid=%b, expected 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d;
        logic v;
        rsp_ready = 1'b0; req_valid = 1'b1; req_hi = 1'b0; req_idx = 4'd1;
        tick(1);
        req_valid = 1'b0;
        ifu_valid = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: valid=%b data=%h ready=%b, expected 0 0 1",
                     rsp_valid, rsp_data, req_ready);
        end
        rsp_ready = 1'b1;
        tick(1);
        reset = 1'b1;
        tick(1);
        ifu_valid = 1'b0;
        do_read(4'd1, 1'b0, d, v);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL first_cycle_rise: got %0d, expected 1", d);
        end
        do_read(4'd0, 1'b0, d, v);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("FAIL cycles_after_reset: got %0d, expected 2", d);
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; clear = 1'b0;
        ifu_valid = 1'b0; icache_valid = 1'b0; icache_start = 1'b0; icache_isHit = 1'b0;
        lsu_ren = 1'b0; lsu_wen = 1'b0; lsu_addr = 32'h0; lsu_isWaiting = 1'b0;
        req_valid = 1'b0; req_idx = 4'd0; req_hi = 1'b0; rsp_ready = 1'b1;
        tick(2);
        test_reset();
        reset = 1'b1;
        test_cycles();
        test_ifu();
        test_icache();
        test_lsu();
        test_clear_disable();
        test_wrap();
        test_back_to_back();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
